// File: rtl/vc_scheduler.sv
// vc_scheduler: picks one of two VC FIFO heads per cycle for two destination FIFOs,
// with VC0 priority bounded by a programmable starvation limit for VC1.
module vc_scheduler #(
    parameter int DATA_W   = 6,
    parameter int DEST_BIT = 4
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              init,
    input  logic [3:0]        starve_limit_i,
    input  logic              vc0_empty,
    input  logic              vc1_empty,
    input  logic [DATA_W-1:0] vc0_data,
    input  logic [DATA_W-1:0] vc1_data,
    input  logic              d0_pause,
    input  logic              d1_pause,
    output logic              vc0_pop,
    output logic              vc1_pop,
    output logic              d0_push,
    output logic              d1_push,
    output logic [DATA_W-1:0] data_out,
    output logic              idle_out,
    output logic              active_out
);
    localparam logic [1:0] ST_INIT   = 2'd0;
    localparam logic [1:0] ST_IDLE   = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [3:0]        limit_q, limit_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              d0_push_q, d0_push_d;
    logic              d1_push_q, d1_push_d;
    logic              run, elig0, elig1, starve, grant0, grant1, grant;
    logic [DATA_W-1:0] word;

    always_comb begin
        run       = (state_q == ST_IDLE || state_q == ST_ACTIVE) && !init;
        // pause is looked up for the destination of each head word only
        elig0     = run && !vc0_empty && !(vc0_data[DEST_BIT] ? d1_pause : d0_pause);
        elig1     = run && !vc1_empty && !(vc1_data[DEST_BIT] ? d1_pause : d0_pause);
        starve    = elig1 && limit_q != 4'd0 && cnt_q == limit_q;
        grant1    = elig1 && (!elig0 || starve);
        grant0    = elig0 && !grant1;
        grant     = grant0 || grant1;
        cnt_d     = (grant0 && elig1) ? (cnt_q == 4'hF ? cnt_q : cnt_q + 4'd1) : 4'd0;
        word      = grant1 ? vc1_data : vc0_data;
        data_d    = grant ? word : data_q;
        d1_push_d = grant && word[DEST_BIT];
        d0_push_d = grant && !word[DEST_BIT];
        limit_d   = (state_q == ST_INIT && init) ? starve_limit_i : limit_q;
        state_d   = state_q;
        case (state_q)
            ST_INIT:   state_d = init ? ST_INIT : ST_IDLE;
            ST_IDLE:   state_d = init ? ST_INIT : (grant ? ST_ACTIVE : ST_IDLE);
            ST_ACTIVE: state_d = init ? ST_INIT :
                                 (vc0_empty && vc1_empty && !d0_push_q && !d1_push_q) ? ST_IDLE : ST_ACTIVE;
            default:   state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q   <= ST_INIT;
            limit_q   <= 4'd0;
            cnt_q     <= 4'd0;
            data_q    <= '0;
            d0_push_q <= 1'b0;
            d1_push_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            limit_q   <= limit_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            d0_push_q <= d0_push_d;
            d1_push_q <= d1_push_d;
        end
    end

    assign vc0_pop    = grant0;
    assign vc1_pop    = grant1;
    assign d0_push    = d0_push_q;
    assign d1_push    = d1_push_q;
    assign data_out   = data_q;
    assign idle_out   = state_q == ST_IDLE;
    assign active_out = state_q == ST_ACTIVE;
endmodule
